lsu_bus_ctrl: RTL and testbench

Load/store bus controller between the core's execute stage and the external data-memory bus. It accepts one load or store request at a time and drives DAD/DDT/MREQ/WRITE/SIZE. It waits for the active-low ACKD_n acknowledge, then returns the load data aligned and sign/zero-extended per RISC-V funct3. A stall output holds the core's PC for as many cycles as the bus needs.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 54 +++++
 rtl/lsu_bus_ctrl.sv | 140 ++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store bus controller.
// The optional bus timeout is enabled with the LSU_TIMEOUT_EN macro (see lsu_bus_ctrl).
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic [1:0] size_of(input logic [2:0] func);
        case (func[1:0])
            2'b00:   size_of = SZ_BYTE;
            2'b01:   size_of = SZ_HALF;
            default: size_of = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication, load extraction/extension,
// and illegal/misaligned request detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func,
    input  logic [1:0]  addr_lo,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic        err
);

    logic        illegal;
    logic        misalign;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        illegal  = (func == 3'b011) || (func[2:1] == 2'b11) || (write && func[2]);
        misalign = ((func[1:0] == 2'b01) && addr_lo[0]) ||
                   ((func[1:0] == 2'b10) && (addr_lo != 2'b00));
        err      = illegal || misalign;
    end

    always_comb begin
        case (func[1:0])
            2'b00:   st_data = {4{wdata[7:0]}};
            2'b01:   st_data = {2{wdata[15:0]}};
            default: st_data = wdata;
        endcase
    end

    // Little-endian lanes: byte lane = addr[1:0], half lane = addr[1]
    always_comb begin
        case (addr_lo)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (func)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: one access at a time, IDLE -> BUS -> RESP.
// Define LSU_TIMEOUT_EN to abort bus cycles that see no ACKD_n within TIMEOUT_CYC cycles.
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    output logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    input  logic        ACKD_n
);

    state_t      state;
    logic [2:0]  lat_func;
    logic [1:0]  lat_addr_lo;
    logic [31:0] ddt_out;
    logic        ddt_oe;
    logic        to_hit;

    logic [2:0]  al_func;
    logic [1:0]  al_addr_lo;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic        al_err;

    // In IDLE the aligner judges the incoming request; afterwards it decodes the latched one
    assign al_func    = (state == ST_IDLE) ? req_func : lat_func;
    assign al_addr_lo = (state == ST_IDLE) ? req_addr[1:0] : lat_addr_lo;

    lsu_align u_align (
        .func      (al_func),
        .addr_lo   (al_addr_lo),
        .write     (req_write),
        .wdata     (req_wdata),
        .bus_rdata (DDT),
        .st_data   (st_data),
        .ld_data   (ld_data),
        .err       (al_err)
    );

    assign req_ready = (state == ST_IDLE);
    assign stall     = req_valid & ~resp_valid;
    assign DDT       = ddt_oe ? ddt_out : 'z;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state != ST_BUS)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = (to_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            lat_func    <= '0;
            lat_addr_lo <= '0;
            ddt_out     <= '0;
            ddt_oe      <= 1'b0;
            MREQ        <= 1'b0;
            WRITE       <= 1'b0;
            SIZE        <= SZ_WORD;
            DAD         <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_func    <= req_func;
                        lat_addr_lo <= req_addr[1:0];
                        if (al_err) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state   <= ST_BUS;
                            MREQ    <= 1'b1;
                            WRITE   <= req_write;
                            DAD     <= req_addr;
                            SIZE    <= size_of(req_func);
                            ddt_oe  <= req_write;
                            ddt_out <= st_data;
                        end
                    end
                end
                ST_BUS: begin
                    if (!ACKD_n || to_hit) begin
                        state      <= ST_RESP;
                        MREQ       <= 1'b0;
                        WRITE      <= 1'b0;
                        ddt_oe     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= ACKD_n;
                        resp_rdata <= (ACKD_n || WRITE) ? 32'd0 : ld_data;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Core must not change a pending request before it is accepted
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (req_valid && !req_ready) |=>
            (!req_valid || $stable({req_write, req_func, req_addr, req_wdata})));
    a_timeout_cfg: assert property (@(posedge clk) TIMEOUT_CYC >= 1);
`endif

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Randomized self-checking bench for lsu_bus_ctrl with a behavioural memory/bus model.
module tb_lsu_bus_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_func = 3'b010;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic [31:0] DAD;
    wire  [31:0] DDT;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic        ACKD_n = 1'b1;

    logic        ddt_en = 1'b0;
    logic [31:0] ddt_drv = '0;
    assign DDT = ddt_en ? ddt_drv : 'z;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_bus_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .stall(stall), .DAD(DAD), .DDT(DDT), .MREQ(MREQ), .WRITE(WRITE),
        .SIZE(SIZE), .ACKD_n(ACKD_n)
    );

    // One access from the core side, bus side answered after 'waits' wait states.
    // Called at posedge+1 with the controller idle; returns at posedge+1.
    task automatic access(input logic wr, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] bus, input int waits,
                          input string name);
        int nbytes, lane, acc, bus_k, mreq_n, stall_n, lat;
        bit legal, tmo, err, done;
        logic [31:0] v, e_rdata, e_ddt;
        logic [1:0]  e_size;
        logic [31:0] g_rdata;
        logic        g_err;
        nbytes = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        legal  = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5) && !(wr && f[2]);
        legal  = legal && ((a % nbytes) == 0);
        tmo    = 1'b0;
`ifdef LSU_TIMEOUT_EN
        tmo    = legal && (waits >= TO);
`endif
        err    = !legal || tmo;
        lane   = int'(a % 4);
        if (nbytes == 1) begin
            v = (bus >> (8 * lane)) & 32'hFF;
            if (!f[2] && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (nbytes == 2) begin
            v = (bus >> (16 * (lane / 2))) & 32'hFFFF;
            if (!f[2] && v >= 32768) v = v | 32'hFFFF_0000;
        end else v = bus;
        e_rdata = (err || wr) ? 32'd0 : v;
        e_ddt   = (nbytes == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                  (nbytes == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        e_size  = (nbytes == 4) ? 2'b00 : (nbytes == 2) ? 2'b01 : 2'b10;

        req_write = wr; req_func = f; req_addr = a; req_wdata = wd;
        req_valid = 1'b1; ACKD_n = 1'b1; ddt_en = 1'b0;
        acc = -1; bus_k = 0; mreq_n = 0; stall_n = 0; lat = -1; done = 0;
        g_rdata = '0; g_err = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (ACKD_n == 1'b0) begin ACKD_n = 1'b1; ddt_en = 1'b0; end
            if (stall) stall_n++;
            if (MREQ) begin
                if (mreq_n == 0) begin
                    checks++;
                    if (DAD !== a || SIZE !== e_size || WRITE !== wr || (wr && DDT !== e_ddt))
                        $display("FAIL %s.bus got DAD=%h SIZE=%b WRITE=%b DDT=%h exp DAD=%h SIZE=%b WRITE=%b DDT=%h",
                                 name, DAD, SIZE, WRITE, DDT, a, e_size, wr, e_ddt);
                    else passed++;
                end
                mreq_n++;
                if (bus_k == waits) begin
                    ACKD_n = 1'b0;
                    if (!wr) begin ddt_en = 1'b1; ddt_drv = bus; end
                end
                bus_k++;
            end
            if (resp_valid) begin
                g_rdata = resp_rdata; g_err = resp_err; lat = cyc - acc; done = 1;
            end
            if (req_valid && req_ready && acc < 0) acc = cyc + 1;
        end
        req_valid = 1'b0; ACKD_n = 1'b1; ddt_en = 1'b0;
        checks++;
        if (!done) $display("FAIL %s.resp no resp_valid within 200 cycles", name);
        else passed++;
        checks++;
        if (g_err !== err || g_rdata !== e_rdata)
            $display("FAIL %s.data got err=%b rdata=%h exp err=%b rdata=%h", name, g_err, g_rdata, err, e_rdata);
        else passed++;
        checks++;
        if (lat !== (!legal ? 0 : tmo ? TO : waits + 1))
            $display("FAIL %s.latency got %0d exp %0d", name, lat, (!legal ? 0 : tmo ? TO : waits + 1));
        else passed++;
        checks++;
        if (mreq_n !== (!legal ? 0 : tmo ? TO : waits + 1) || stall_n !== (!legal ? 1 : tmo ? TO + 1 : waits + 2))
            $display("FAIL %s.cycles got mreq=%0d stall=%0d exp mreq=%0d stall=%0d", name, mreq_n, stall_n,
                     (!legal ? 0 : tmo ? TO : waits + 1), (!legal ? 1 : tmo ? TO + 1 : waits + 2));
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (MREQ !== 1'b0 || WRITE !== 1'b0 || SIZE !== 2'b00 || DAD !== 32'd0)
            $display("FAIL reset.bus got MREQ=%b WRITE=%b SIZE=%b DAD=%h exp 0 0 00 0", MREQ, WRITE, SIZE, DAD);
        else passed++;
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0 || req_ready !== 1'b1 || stall !== 1'b0)
            $display("FAIL reset.core got rv=%b re=%b rd=%h rdy=%b stall=%b exp 0 0 0 1 0",
                     resp_valid, resp_err, resp_rdata, req_ready, stall);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        access(1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 0, "lw");
        access(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_FF7F, 3, "lb");
        access(1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'h80FF_FF7F, 3, "lbu");
        access(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 1, "sh");
        access(1'b1, 3'b000, 32'h0000_2001, 32'h0000_0042, 32'd0, 0, "sb");
        access(1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'h8001_7FFF, 2, "lhu");
        access(1'b0, 3'b010, 32'h0000_1002, 32'd0, 32'h1111_1111, 0, "lw_misalign");
        access(1'b0, 3'b111, 32'h0000_1000, 32'd0, 32'h1111_1111, 0, "illegal_f3");
        access(1'b1, 3'b100, 32'h0000_1000, 32'd5, 32'd0, 0, "illegal_store");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(),
                   $urandom(), int'($urandom_range(0, 4)), "random");
        end
    endtask

    task automatic test_stale_ack();
        int bad;
        bad = 0;
        ACKD_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid || MREQ) bad++;
        end
        ACKD_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bad !== 0) $display("FAIL stale_ack got %0d cycles with activity exp 0", bad);
        else passed++;
        access(1'b0, 3'b001, 32'h0000_3006, 32'd0, 32'hC0DE_1234, 0, "after_stale");
    endtask

    task automatic test_reset_in_bus();
        int n, seen;
        req_write = 1'b1; req_func = 3'b010; req_addr = 32'h0000_3000; req_wdata = 32'hA5A5_1234;
        req_valid = 1'b1; ACKD_n = 1'b1;
        n = 0;
        for (int t = 0; t < 20 && n < 3; t++) begin
            @(negedge clk);
            if (MREQ) n++;
        end
        checks++;
        if (n !== 3) $display("FAIL rst_bus.reach got %0d bus cycles exp 3", n);
        else passed++;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (MREQ !== 1'b0 || WRITE !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL rst_bus.async got MREQ=%b WRITE=%b rv=%b rdy=%b exp 0 0 0 1", MREQ, WRITE, resp_valid, req_ready);
        else passed++;
        ddt_drv = 32'h5A5A_0F0F; ddt_en = 1'b1;
        #1;
        checks++;
        if (DDT !== 32'h5A5A_0F0F) $display("FAIL rst_bus.ddt_release got %h exp 5a5a0f0f", DDT);
        else passed++;
        ddt_en = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL rst_bus.no_resp got %0d responses exp 0", seen);
        else passed++;
        @(posedge clk); #1;
        access(1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'h0BAD_F00D, 1, "after_rst");
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        access(1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'h1234_5678, 1000, "timeout");
        checks++;
        if (req_ready !== 1'b1) $display("FAIL timeout.idle got req_ready=%b exp 1", req_ready);
        else passed++;
        access(1'b0, 3'b000, 32'h0000_4001, 32'd0, 32'h0000_8000, TO - 2, "near_timeout");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_stale_ack();
        test_random();
        test_reset_in_bus();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
